// File: rtl/sprite_walk_controller.sv
// Tile-locked overworld walk controller: turns, steps the camera one tile per move,
// bumps at walls/map edges, and sequences the 4-phase walk animation per frame_tick.
module sprite_walk_controller #(
  parameter int TILE       = 16,
  parameter int STEP       = 1,
  parameter int ANIM_TICKS = 8,
  parameter int SPRITE_W   = 19,
  parameter int MAP_W      = 1280,
  parameter int MAP_H      = 960,
  parameter int VIEW_W     = 640,
  parameter int VIEW_H     = 480,
  parameter int CAM_W      = 11,
  parameter int INIT_X     = 96,
  parameter int INIT_Y     = 96
) (
  input  logic                              Clk,
  input  logic                              Reset_n,
  input  logic                              frame_tick,
  input  logic                              move_req,
  input  logic [1:0]                        move_dir,
  input  logic                              blocked,
  output logic [CAM_W-1:0]                  cam_x,
  output logic [CAM_W-1:0]                  cam_y,
  output logic [1:0]                        facing,
  output logic                              walking,
  output logic [1:0]                        anim_phase,
  output logic [$clog2(12*SPRITE_W)-1:0]    sheet_col
);

  localparam int COL_W = $clog2(12*SPRITE_W);
  localparam int RW    = $clog2(TILE + 1);
  localparam int AW    = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;

  localparam logic [CAM_W-1:0] STEP_C    = CAM_W'(STEP);
  localparam logic [CAM_W-1:0] INIT_X_C  = CAM_W'(INIT_X);
  localparam logic [CAM_W-1:0] INIT_Y_C  = CAM_W'(INIT_Y);
  localparam logic [RW-1:0]    REM_TILE  = RW'(TILE);
  localparam logic [RW-1:0]    REM_STEP  = RW'(STEP);
  localparam logic [RW-1:0]    REM_BUMP  = RW'(TILE / STEP);
  localparam logic [RW-1:0]    REM_ONE   = RW'(1);
  localparam logic [AW-1:0]    ANIM_LAST = AW'(ANIM_TICKS - 1);

  typedef enum logic [1:0] {IDLE, WALK, BUMP} state_t;

  state_t             state, state_n;
  logic [CAM_W-1:0]   cam_x_n, cam_y_n, step_x, step_y;
  logic [1:0]         facing_n, phase_n, phase_adv;
  logic [AW-1:0]      anim_cnt, cnt_n, cnt_adv;
  logic [RW-1:0]      remaining, rem_n;
  logic               walking_n;
  logic [COL_W-1:0]   sheet_col_n;

  // True when one more tile in direction d would put the view past the map.
  function automatic logic at_edge(input logic [1:0] d, input logic [CAM_W-1:0] x,
                                   input logic [CAM_W-1:0] y);
    int xi, yi;
    xi = int'(x);
    yi = int'(y);
    case (d)
      2'd0:    return yi < TILE;
      2'd1:    return xi + VIEW_W + TILE > MAP_W;
      2'd2:    return yi + VIEW_H + TILE > MAP_H;
      default: return xi < TILE;
    endcase
  endfunction

  function automatic logic [COL_W-1:0] col_of(input logic [1:0] d, input logic [1:0] ph);
    int slot, f;
    case (d)
      2'd0:    slot = 2;
      2'd1:    slot = 3;
      2'd2:    slot = 0;
      default: slot = 1;
    endcase
    case (ph)
      2'd1:    f = 0;
      2'd3:    f = 2;
      default: f = 1;
    endcase
    return COL_W'(slot * 3 * SPRITE_W + f * SPRITE_W);
  endfunction

  always_comb begin
    step_x = cam_x;
    step_y = cam_y;
    case (facing)
      2'd0:    step_y = cam_y - STEP_C;
      2'd1:    step_x = cam_x + STEP_C;
      2'd2:    step_y = cam_y + STEP_C;
      default: step_x = cam_x - STEP_C;
    endcase
    if (anim_cnt == ANIM_LAST) begin
      cnt_adv   = '0;
      phase_adv = anim_phase + 2'd1;
    end else begin
      cnt_adv   = anim_cnt + AW'(1);
      phase_adv = anim_phase;
    end
  end

  always_comb begin
    state_n  = state;
    cam_x_n  = cam_x;
    cam_y_n  = cam_y;
    facing_n = facing;
    phase_n  = anim_phase;
    cnt_n    = anim_cnt;
    rem_n    = remaining;
    if (frame_tick) begin
      case (state)
        IDLE: begin
          if (move_req) begin
            if (move_dir != facing) begin
              facing_n = move_dir;
            end else begin
              phase_n = 2'd1;
              cnt_n   = '0;
              if (blocked || at_edge(facing, cam_x, cam_y)) begin
                state_n = BUMP;
                rem_n   = REM_BUMP;
              end else begin
                state_n = WALK;
                rem_n   = REM_TILE;
              end
            end
          end
        end
        WALK: begin
          cam_x_n = step_x;
          cam_y_n = step_y;
          cnt_n   = cnt_adv;
          phase_n = phase_adv;
          rem_n   = remaining - REM_STEP;
          // Tile boundary: chain straight into the next tile if the key is still held.
          if (remaining == REM_STEP) begin
            if (move_req && move_dir == facing && !blocked &&
                !at_edge(facing, step_x, step_y)) begin
              rem_n = REM_TILE;
            end else begin
              state_n = IDLE;
              phase_n = 2'd0;
              cnt_n   = '0;
            end
          end
        end
        BUMP: begin
          cnt_n   = cnt_adv;
          phase_n = phase_adv;
          rem_n   = remaining - REM_ONE;
          if (remaining == REM_ONE) begin
            state_n = IDLE;
            phase_n = 2'd0;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = IDLE;
          phase_n = 2'd0;
          cnt_n   = '0;
        end
      endcase
    end
    walking_n   = (state_n != IDLE);
    sheet_col_n = col_of(facing_n, phase_n);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state      <= IDLE;
      cam_x      <= INIT_X_C;
      cam_y      <= INIT_Y_C;
      facing     <= 2'd2;
      walking    <= 1'b0;
      anim_phase <= 2'd0;
      anim_cnt   <= '0;
      remaining  <= '0;
      sheet_col  <= COL_W'(SPRITE_W);
    end else begin
      state      <= state_n;
      cam_x      <= cam_x_n;
      cam_y      <= cam_y_n;
      facing     <= facing_n;
      walking    <= walking_n;
      anim_phase <= phase_n;
      anim_cnt   <= cnt_n;
      remaining  <= rem_n;
      sheet_col  <= sheet_col_n;
    end
  end

endmodule
